matrix_multiply_mac_top: RTL and testbench
==========================================

// Module: matrix_multiply_mac_top
// PURPOSE
//  Runtime-dimensioned successor to the fixed-size matrix multiply engine: computes Z = X*Y (or Z += X*Y)
//  over host-loaded X/Y RAMs, dimensions chosen per run up to compile-time maxima. Adds signed mode,
//  accumulate mode, saturating output, a done pulse and dimension-error reporting.
//  Sits behind the same host RAM port (addr/wen/sel/data) used by the DFR control logic.
// PARAMETERS
//  ADDR_WIDTH     8   host/RAM address width; must hold MAX_ROWS*MAX_INNER, MAX_INNER*MAX_COLS, MAX_ROWS*MAX_COLS
//  DATA_WIDTH     32  element width of X, Y and Z
//  MAX_ROWS       8   max X rows (Z rows)
//  MAX_COLS       8   max Y cols (Z cols)
//  MAX_INNER      8   max X cols = Y rows
//  ACC_WIDTH      2*DATA_WIDTH+$clog2(MAX_INNER)+1  internal accumulator width (never overflows)
// PORTS
//  clk           in   1           clock, all logic on rising edge
//  rst           in   1           asynchronous, active-low reset
//  start         in   1           1-cycle run request, sampled only in IDLE
//  x_rows        in   8           rows of X for this run, sampled with start
//  y_cols        in   8           cols of Y for this run, sampled with start
//  inner         in   8           X cols / Y rows for this run, sampled with start
//  mode_signed   in   1           1: two's-complement operands; 0: unsigned; sampled with start
//  mode_accum    in   1           1: Z += X*Y; 0: Z = X*Y; sampled with start
//  ram_addr      in   ADDR_WIDTH  host RAM address
//  ram_wen       in   1           host write enable
//  ram_sel       in   2           00 X, 01 Y, 10 Z, 11 reserved (reads 0, writes dropped)
//  ram_data_in   in   DATA_WIDTH  host write data
//  busy          out  1           run in progress
//  done          out  1           1-cycle pulse after last Z write
//  err           out  1           sticky: last start had illegal dimensions
//  ram_data_out  out  DATA_WIDTH  host read data, registered (1-cycle latency from ram_addr/ram_sel)
// BEHAVIOUR
//  Reset: busy=0, done=0, err=0, ram_data_out=0, FSM=IDLE, counters 0. RAM contents not cleared.
//  Layout row-major: X[r*inner+k], Y[k*y_cols+c], Z[r*y_cols+c]; addresses beyond run dims untouched.
//  Host writes honoured only when busy=0; while busy writes dropped, ram_data_out held at 0.
//  FSM: IDLE -> MAC -> DRAIN -> WRITE -> (MAC next element | DONE) -> IDLE.
//   IDLE: start with 1<=x_rows<=MAX_ROWS, 1<=y_cols<=MAX_COLS, 1<=inner<=MAX_INNER -> latch dims/modes,
//     clear err, busy=1 next cycle, go MAC(r=0,c=0). Illegal dims -> err=1 next cycle, stay IDLE, no done.
//   MAC: inner cycles; cycle k issues X/Y reads for k (1-cycle RAM latency); product of k-1 accumulated;
//     first MAC cycle clears acc and (accum mode) issues Z[r][c] read.
//   DRAIN: 1 cycle, adds last product.
//   WRITE: 1 cycle; Z[r][c] <= sat(acc + (accum ? Zold : 0)); advance c, wrap c->0 and r++; after last
//     element go DONE.
//   DONE: 1 cycle, done=1, busy=0 next cycle, return IDLE.
//  Busy cycles per run = x_rows*y_cols*(inner+2)+1.
//  Arithmetic: products/sums in ACC_WIDTH, sign- or zero-extended per mode_signed; accumulate addend Zold
//   interpreted per mode_signed. Saturation to DATA_WIDTH: signed clamps to [-2^(D-1), 2^(D-1)-1];
//   unsigned clamps to 2^D-1 (no negatives possible).
//  start while busy ignored (no restart, inputs not resampled). start and ram_wen same cycle in IDLE:
//   write completes, run starts; run reads see the new value.
//  Reset mid-run: immediate IDLE, busy=0, no done; Z holds partial results.
// TESTING
//  1 Load X 5x4 = 1..20, Y 4x3 = 1..12, start(5,3,4,unsigned) -> Z row0 = 70,80,90; Z[1][0]=158;
//    busy high exactly 91 cycles; single done pulse.
//  2 Rerun test 1 with mode_accum=1 -> Z[0][0]=140, Z[0][2]=180, Z[1][0]=316.
//  3 1x1x1 signed: X=-3, Y=5 -> Z=0xFFFFFFF1; same unsigned X=0xFFFFFFFF, Y=2 -> Z=0xFFFFFFFF (saturated).
//  4 Signed saturation: X=0x7FFFFFFF, Y=2 -> 0x7FFFFFFF; X=0x80000000, Y=2 -> 0x80000000.
//  5 start with inner=0, then x_rows=MAX_ROWS+1 -> err=1, busy stays 0, no done, Z unchanged;
//    following legal start clears err.
//  6 Assert rst low mid-run (cycle 20 of test 1) -> busy=0 asynchronously, no done; host writes to X
//    while busy dropped (readback unchanged); after reset a fresh run gives test-1 results.

Source files
------------

// File: rtl/matrix_multiply_mac_top_if.sv
// Host-side bundle for the matrix multiply MAC engine:
// run control, status flags and the shared X/Y/Z RAM port.
interface matrix_multiply_mac_top_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [7:0]            x_rows;
    logic [7:0]            y_cols;
    logic [7:0]            inner;
    logic                  mode_signed;
    logic                  mode_accum;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_wen;
    logic [1:0]            ram_sel;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [DATA_WIDTH-1:0] ram_data_out;

    modport master (
        output start, x_rows, y_cols, inner,
        output mode_signed, mode_accum,
        output ram_addr, ram_wen, ram_sel, ram_data_in,
        input  busy, done, err, ram_data_out
    );

    modport slave (
        input  start, x_rows, y_cols, inner,
        input  mode_signed, mode_accum,
        input  ram_addr, ram_wen, ram_sel, ram_data_in,
        output busy, done, err, ram_data_out
    );
endinterface

// File: rtl/matrix_multiply_mac_top.sv
// Runtime-dimensioned Z = X*Y (or Z += X*Y) engine over host-loaded RAMs,
// with signed/unsigned operands, saturating writeback and dimension checking.
module matrix_multiply_mac_top #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_ROWS   = 8,
    parameter int MAX_COLS   = 8,
    parameter int MAX_INNER  = 8,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(MAX_INNER) + 1
) (
    input logic                      clk,
    input logic                      rst,
    matrix_multiply_mac_top_if.slave bus
);
    localparam int X_DEPTH = MAX_ROWS * MAX_INNER;
    localparam int Y_DEPTH = MAX_INNER * MAX_COLS;
    localparam int Z_DEPTH = MAX_ROWS * MAX_COLS;
    localparam int XW      = $clog2(X_DEPTH);
    localparam int YW      = $clog2(Y_DEPTH);
    localparam int ZW      = $clog2(Z_DEPTH);
    localparam int EXT     = ACC_WIDTH - DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] S_MAX =
        {{(EXT + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] S_MIN =
        {{(EXT + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] U_MAX =
        {{EXT{1'b0}}, {DATA_WIDTH{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [7:0] rows_q, rows_d;
    logic [7:0] cols_q, cols_d;
    logic [7:0] inner_q, inner_d;
    logic       sgn_q, sgn_d;
    logic       accm_q, accm_d;
    logic [7:0] r_q, r_d;
    logic [7:0] c_q, c_d;
    logic [7:0] k_q, k_d;
    logic       err_q, err_d;

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0]       dout_q, dout_d;

    logic [DATA_WIDTH-1:0] x_mem_q [X_DEPTH];
    logic [DATA_WIDTH-1:0] y_mem_q [Y_DEPTH];
    logic [DATA_WIDTH-1:0] z_mem_q [Z_DEPTH];
    logic [DATA_WIDTH-1:0] x_rd_q;
    logic [DATA_WIDTH-1:0] y_rd_q;
    logic [DATA_WIDTH-1:0] z_rd_q;

    logic busy;
    logic mac_en;
    logic drain_en;
    logic wr_en;
    logic dims_ok;
    logic last_k;
    logic last_c;
    logic last_r;

    logic [ADDR_WIDTH-1:0] haddr;
    logic                  x_in, y_in, z_in;
    logic                  host_wr;
    logic                  x_hw, y_hw, z_hw;

    logic [XW-1:0] x_ra;
    logic [YW-1:0] y_ra;
    logic [ZW-1:0] z_ix;

    logic                  z_we;
    logic [ZW-1:0]         z_wa;
    logic [DATA_WIDTH-1:0] z_wd;

    logic signed [ACC_WIDTH-1:0] x_ext, y_ext, prod;
    logic signed [ACC_WIDTH-1:0] z_add, sum;
    logic [DATA_WIDTH-1:0]       sat;

    function automatic logic signed [ACC_WIDTH-1:0] ext(
        input logic [DATA_WIDTH-1:0] v,
        input logic                  s
    );
        return s ? {{EXT{v[DATA_WIDTH-1]}}, v} : {{EXT{1'b0}}, v};
    endfunction

    assign haddr = bus.ram_addr;
    assign x_in  = int'(haddr) < X_DEPTH;
    assign y_in  = int'(haddr) < Y_DEPTH;
    assign z_in  = int'(haddr) < Z_DEPTH;

    assign dims_ok = (bus.x_rows != 8'd0) && (bus.x_rows <= 8'(MAX_ROWS))
                  && (bus.y_cols != 8'd0) && (bus.y_cols <= 8'(MAX_COLS))
                  && (bus.inner  != 8'd0) && (bus.inner  <= 8'(MAX_INNER));

    assign last_k = (k_q == inner_q - 8'd1);
    assign last_c = (c_q == cols_q - 8'd1);
    assign last_r = (r_q == rows_q - 8'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start && dims_ok) state_d = S_MAC;
            S_MAC:   if (last_k) state_d = S_DRAIN;
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: state_d = (last_c && last_r) ? S_DONE : S_MAC;
            S_DONE:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b1;
        bus.done = 1'b0;
        mac_en   = 1'b0;
        drain_en = 1'b0;
        wr_en    = 1'b0;
        unique case (state_q)
            S_IDLE:  busy     = 1'b0;
            S_MAC:   mac_en   = 1'b1;
            S_DRAIN: drain_en = 1'b1;
            S_WRITE: wr_en    = 1'b1;
            S_DONE:  bus.done = 1'b1;
        endcase
    end

    assign bus.busy         = busy;
    assign bus.err          = err_q;
    assign bus.ram_data_out = dout_q;

    // Run-side addresses; the MAC issues reads for step k every cycle.
    assign x_ra = XW'(r_q * inner_q + k_q);
    assign y_ra = YW'(k_q * cols_q + c_q);
    assign z_ix = ZW'(r_q * cols_q + c_q);

    assign x_ext = ext(x_rd_q, sgn_q);
    assign y_ext = ext(y_rd_q, sgn_q);
    assign prod  = x_ext * y_ext;
    assign z_add = accm_q ? ext(z_rd_q, sgn_q) : '0;
    assign sum   = acc_q + z_add;

    always_comb begin
        sat = sum[DATA_WIDTH-1:0];
        if (sgn_q) begin
            if (sum > S_MAX) begin
                sat = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
            end else if (sum < S_MIN) begin
                sat = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
            end
        end else if (sum > U_MAX) begin
            sat = '1;
        end
    end

    always_comb begin
        rows_d  = rows_q;
        cols_d  = cols_q;
        inner_d = inner_q;
        sgn_d   = sgn_q;
        accm_d  = accm_q;
        err_d   = err_q;
        r_d     = r_q;
        c_d     = c_q;
        k_d     = k_q;
        acc_d   = acc_q;
        if ((state_q == S_IDLE) && bus.start) begin
            if (dims_ok) begin
                rows_d  = bus.x_rows;
                cols_d  = bus.y_cols;
                inner_d = bus.inner;
                sgn_d   = bus.mode_signed;
                accm_d  = bus.mode_accum;
                err_d   = 1'b0;
                r_d     = 8'd0;
                c_d     = 8'd0;
                k_d     = 8'd0;
            end else begin
                err_d = 1'b1;
            end
        end
        if (mac_en) begin
            k_d   = last_k ? 8'd0 : k_q + 8'd1;
            acc_d = (k_q == 8'd0) ? '0 : acc_q + prod;
        end
        if (drain_en) begin
            acc_d = acc_q + prod;
        end
        if (wr_en) begin
            if (last_c) begin
                c_d = 8'd0;
                r_d = r_q + 8'd1;
            end else begin
                c_d = c_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rows_q  <= 8'd0;
            cols_q  <= 8'd0;
            inner_q <= 8'd0;
            sgn_q   <= 1'b0;
            accm_q  <= 1'b0;
            err_q   <= 1'b0;
            r_q     <= 8'd0;
            c_q     <= 8'd0;
            k_q     <= 8'd0;
            acc_q   <= '0;
            dout_q  <= '0;
        end else begin
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            inner_q <= inner_d;
            sgn_q   <= sgn_d;
            accm_q  <= accm_d;
            err_q   <= err_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
        end
    end

    assign host_wr = bus.ram_wen && !busy;
    assign x_hw    = host_wr && (bus.ram_sel == 2'b00) && x_in;
    assign y_hw    = host_wr && (bus.ram_sel == 2'b01) && y_in;
    assign z_hw    = host_wr && (bus.ram_sel == 2'b10) && z_in;

    assign z_we = z_hw || wr_en;
    assign z_wa = wr_en ? z_ix : haddr[ZW-1:0];
    assign z_wd = wr_en ? sat : bus.ram_data_in;

    // Host readback is blanked for every cycle the engine owns the RAMs.
    always_comb begin
        dout_d = '0;
        if (state_d == S_IDLE) begin
            case (bus.ram_sel)
                2'b00:   if (x_in) dout_d = x_mem_q[haddr[XW-1:0]];
                2'b01:   if (y_in) dout_d = y_mem_q[haddr[YW-1:0]];
                2'b10:   if (z_in) dout_d = z_mem_q[haddr[ZW-1:0]];
                default: dout_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (x_hw) x_mem_q[haddr[XW-1:0]] <= bus.ram_data_in;
        if (y_hw) y_mem_q[haddr[YW-1:0]] <= bus.ram_data_in;
        if (z_we) z_mem_q[z_wa] <= z_wd;
        x_rd_q <= x_mem_q[x_ra];
        y_rd_q <= y_mem_q[y_ra];
        if (mac_en && (k_q == 8'd0)) z_rd_q <= z_mem_q[z_ix];
    end
endmodule

// File: tb/tb_matrix_multiply_mac_top.sv
// Self-checking bench: directed scenarios plus randomized runs
// compared against a plain-arithmetic matrix model.
module tb_matrix_multiply_mac_top;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_multiply_mac_top_if bus ();
    matrix_multiply_mac_top dut (.clk(clk), .rst(rst), .bus(bus));

    int total  = 0;
    int passed = 0;
    logic [31:0] mx [64];
    logic [31:0] my [64];
    logic [31:0] mz [64];

    task automatic host_write(input logic [1:0] sel, input logic [7:0] a,
                              input logic [31:0] d);
        @(negedge clk);
        bus.ram_sel = sel; bus.ram_addr = a;
        bus.ram_data_in = d; bus.ram_wen = 1'b1;
        @(negedge clk);
        bus.ram_wen = 1'b0;
        if (a < 64) begin
            case (sel)
                2'b00: mx[a] = d;
                2'b01: my[a] = d;
                2'b10: mz[a] = d;
                default: ;
            endcase
        end
    endtask

    task automatic host_read(input logic [1:0] sel, input logic [7:0] a,
                             output logic [31:0] d);
        @(negedge clk);
        bus.ram_sel = sel; bus.ram_addr = a;
        @(posedge clk);
        #1 d = bus.ram_data_out;
    endtask

    task automatic do_run(input logic [7:0] xr, yc, inr, input logic s, acc,
                          input int poke, input logic wr,
                          input logic [7:0] wa, input logic [31:0] wd,
                          output int bcnt, output int dcnt);
        @(negedge clk);
        bus.x_rows = xr; bus.y_cols = yc; bus.inner = inr;
        bus.mode_signed = s; bus.mode_accum = acc; bus.start = 1'b1;
        if (wr) begin
            bus.ram_sel = 2'b00; bus.ram_addr = wa;
            bus.ram_data_in = wd; bus.ram_wen = 1'b1;
        end
        @(negedge clk);
        bus.start = 1'b0; bus.ram_wen = 1'b0;
        bcnt = 0; dcnt = 0;
        for (int i = 0; i < 4000; i++) begin
            if (bus.done) dcnt++;
            if (!bus.busy) break;
            bcnt++;
            if (i == poke) begin
                bus.x_rows = 8'd1; bus.y_cols = 8'd1;
                bus.inner = 8'd1; bus.start = 1'b1;
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    function automatic logic signed [71:0] ext72(input logic [31:0] w, input bit s);
        return s ? {{40{w[31]}}, w} : {40'd0, w};
    endfunction

    task automatic model(input int xr, yc, inr, input bit s, acc);
        logic signed [71:0] sum, hi, lo;
        hi = s ? 72'sd2147483647 : 72'sd4294967295;
        lo = s ? -72'sd2147483648 : 72'sd0;
        for (int r = 0; r < xr; r++) begin
            for (int c = 0; c < yc; c++) begin
                sum = 0;
                for (int k = 0; k < inr; k++)
                    sum += ext72(mx[r*inr+k], s) * ext72(my[k*yc+c], s);
                if (acc) sum += ext72(mz[r*yc+c], s);
                if (sum > hi) mz[r*yc+c] = hi[31:0];
                else if (sum < lo) mz[r*yc+c] = lo[31:0];
                else mz[r*yc+c] = sum[31:0];
            end
        end
    endtask

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 5))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.done, bus.err});
        else passed++;
        total++;
        if (bus.ram_data_out !== 32'd0)
            $display("FAIL reset_dout: got %h want 0", bus.ram_data_out);
        else passed++;
        rst = 1'b1;
    endtask

    task automatic test_basic();
        int b, d;
        logic [31:0] v;
        int exp [4] = '{70, 80, 90, 158};
        for (int i = 0; i < 20; i++) host_write(2'b00, 8'(i), 32'(i + 1));
        for (int i = 0; i < 12; i++) host_write(2'b01, 8'(i), 32'(i + 1));
        do_run(5, 3, 4, 0, 0, -1, 0, 0, 0, b, d);
        total++;
        if (b != 91) $display("FAIL basic_busy: got %0d want 91", b); else passed++;
        total++;
        if (d != 1) $display("FAIL basic_done: got %0d want 1", d); else passed++;
        for (int j = 0; j < 4; j++) begin
            host_read(2'b10, 8'(j), v);
            total++;
            if (v !== 32'(exp[j])) $display("FAIL basic_z%0d: got %0d want %0d", j, v, exp[j]);
            else passed++;
        end
    endtask

    task automatic test_accum();
        int b, d;
        logic [31:0] v;
        int adr [3] = '{0, 2, 3};
        int exp [3] = '{140, 180, 316};
        do_run(5, 3, 4, 0, 1, -1, 0, 0, 0, b, d);
        total++;
        if (b != 91 || d != 1) $display("FAIL accum_busy_done: got %0d/%0d want 91/1", b, d);
        else passed++;
        for (int j = 0; j < 3; j++) begin
            host_read(2'b10, 8'(adr[j]), v);
            total++;
            if (v !== 32'(exp[j])) $display("FAIL accum_z%0d: got %0d want %0d", adr[j], v, exp[j]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int b, d;
        logic [31:0] v;
        do_run(5, 3, 4, 0, 0, 10, 1, 0, 32'd2, b, d);
        total++;
        if (b != 91 || d != 1) $display("FAIL b2b_first: got %0d/%0d want 91/1", b, d);
        else passed++;
        do_run(5, 3, 4, 0, 1, -1, 0, 0, 0, b, d);
        total++;
        if (b != 91 || d != 1) $display("FAIL b2b_second: got %0d/%0d want 91/1", b, d);
        else passed++;
        host_read(2'b10, 8'd0, v);
        total++;
        if (v !== 32'd142) $display("FAIL b2b_z0: got %0d want 142", v); else passed++;
        host_read(2'b10, 8'd1, v);
        total++;
        if (v !== 32'd164) $display("FAIL b2b_z1: got %0d want 164", v); else passed++;
        host_write(2'b00, 8'd0, 32'd1);
    endtask

    task automatic test_signed();
        int b, d;
        logic [31:0] v;
        host_write(2'b00, 8'd0, 32'hFFFFFFFD);
        host_write(2'b01, 8'd0, 32'd5);
        do_run(1, 1, 1, 1, 0, -1, 0, 0, 0, b, d);
        total++;
        if (b != 4 || d != 1) $display("FAIL signed_busy_done: got %0d/%0d want 4/1", b, d);
        else passed++;
        host_read(2'b10, 8'd0, v);
        total++;
        if (v !== 32'hFFFFFFF1) $display("FAIL signed_neg: got %h want fffffff1", v); else passed++;
        host_write(2'b00, 8'd0, 32'hFFFFFFFF);
        host_write(2'b01, 8'd0, 32'd2);
        do_run(1, 1, 1, 0, 0, -1, 0, 0, 0, b, d);
        host_read(2'b10, 8'd0, v);
        total++;
        if (v !== 32'hFFFFFFFF) $display("FAIL unsigned_sat: got %h want ffffffff", v); else passed++;
    endtask

    task automatic test_saturation();
        int b, d;
        logic [31:0] v;
        host_write(2'b00, 8'd0, 32'h7FFFFFFF);
        do_run(1, 1, 1, 1, 0, -1, 0, 0, 0, b, d);
        host_read(2'b10, 8'd0, v);
        total++;
        if (v !== 32'h7FFFFFFF) $display("FAIL sat_pos: got %h want 7fffffff", v); else passed++;
        host_write(2'b00, 8'd0, 32'h80000000);
        do_run(1, 1, 1, 1, 0, -1, 0, 0, 0, b, d);
        host_read(2'b10, 8'd0, v);
        total++;
        if (v !== 32'h80000000) $display("FAIL sat_neg: got %h want 80000000", v); else passed++;
    endtask

    task automatic test_dim_err();
        int b, d;
        logic [31:0] v;
        host_write(2'b00, 8'd0, 32'd3);
        do_run(5, 3, 0, 0, 0, -1, 0, 0, 0, b, d);
        total++;
        if (b != 0 || d != 0 || bus.err !== 1'b1)
            $display("FAIL err_inner0: got busy=%0d done=%0d err=%b want 0/0/1", b, d, bus.err);
        else passed++;
        do_run(9, 1, 1, 0, 0, -1, 0, 0, 0, b, d);
        total++;
        if (b != 0 || d != 0 || bus.err !== 1'b1)
            $display("FAIL err_rows: got busy=%0d done=%0d err=%b want 0/0/1", b, d, bus.err);
        else passed++;
        host_read(2'b10, 8'd0, v);
        total++;
        if (v !== 32'h80000000) $display("FAIL err_z_kept: got %h want 80000000", v); else passed++;
        do_run(1, 1, 1, 0, 0, -1, 0, 0, 0, b, d);
        total++;
        if (bus.err !== 1'b0 || b != 4) $display("FAIL err_clear: got err=%b busy=%0d want 0/4", bus.err, b);
        else passed++;
        host_read(2'b10, 8'd0, v);
        total++;
        if (v !== 32'd6) $display("FAIL err_legal_z: got %0d want 6", v); else passed++;
    endtask

    task automatic test_reset_mid_run();
        int b, d, seen;
        logic [31:0] v;
        int exp [4] = '{70, 80, 90, 158};
        host_write(2'b00, 8'd0, 32'd1);
        host_write(2'b01, 8'd0, 32'd1);
        @(negedge clk);
        bus.x_rows = 5; bus.y_cols = 3; bus.inner = 4;
        bus.mode_signed = 0; bus.mode_accum = 0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        repeat (18) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        total++;
        if (bus.ram_data_out !== 32'd0) $display("FAIL busy_dout: got %h want 0", bus.ram_data_out);
        else passed++;
        bus.ram_sel = 2'b00; bus.ram_addr = 8'd0;
        bus.ram_data_in = 32'd999; bus.ram_wen = 1'b1;
        @(negedge clk);
        bus.ram_wen = 1'b0;
        #2 rst = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || seen != 0)
            $display("FAIL async_reset: got busy=%b done=%b seen=%0d want 0/0/0", bus.busy, bus.done, seen);
        else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        host_read(2'b00, 8'd0, v);
        total++;
        if (v !== 32'd1) $display("FAIL busy_write_dropped: got %0d want 1", v); else passed++;
        do_run(5, 3, 4, 0, 0, -1, 0, 0, 0, b, d);
        total++;
        if (b != 91 || d != 1) $display("FAIL rerun_busy_done: got %0d/%0d want 91/1", b, d);
        else passed++;
        for (int j = 0; j < 4; j++) begin
            host_read(2'b10, 8'(j), v);
            total++;
            if (v !== 32'(exp[j])) $display("FAIL rerun_z%0d: got %0d want %0d", j, v, exp[j]);
            else passed++;
        end
    endtask

    task automatic test_random();
        int b, d, xr, yc, inr;
        bit s, acc;
        logic [31:0] v;
        for (int i = 0; i < 64; i++) begin
            host_write(2'b00, 8'(i), rv());
            host_write(2'b01, 8'(i), rv());
            host_write(2'b10, 8'(i), rv());
        end
        for (int n = 0; n < 6; n++) begin
            xr  = $urandom_range(1, 8);
            yc  = $urandom_range(1, 8);
            inr = $urandom_range(1, 8);
            s   = 1'($urandom_range(0, 1));
            acc = 1'($urandom_range(0, 1));
            for (int i = 0; i < xr * inr; i++) host_write(2'b00, 8'(i), rv());
            for (int i = 0; i < inr * yc; i++) host_write(2'b01, 8'(i), rv());
            do_run(8'(xr), 8'(yc), 8'(inr), s, acc, -1, 0, 0, 0, b, d);
            total++;
            if (b != xr * yc * (inr + 2) + 1 || d != 1)
                $display("FAIL rand%0d_busy_done: got %0d/%0d want %0d/1", n, b, d, xr * yc * (inr + 2) + 1);
            else passed++;
            model(xr, yc, inr, s, acc);
            for (int i = 0; i < 64; i++) begin
                host_read(2'b10, 8'(i), v);
                total++;
                if (v !== mz[i]) $display("FAIL rand%0d_z%0d: got %h want %h", n, i, v, mz[i]);
                else passed++;
            end
        end
    endtask

    initial begin
        bus.start = 0; bus.x_rows = 0; bus.y_cols = 0; bus.inner = 0;
        bus.mode_signed = 0; bus.mode_accum = 0;
        bus.ram_addr = 0; bus.ram_wen = 0; bus.ram_sel = 0; bus.ram_data_in = 0;
        test_reset();
        test_basic();
        test_accum();
        test_back_to_back();
        test_signed();
        test_saturation();
        test_dim_err();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
